// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: hides the one-cycle FIFO read latency behind a 2-entry skid buffer
// and presents the words on a valid/ready stream, counting delivered words.
module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH = 7,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH:0]   fifo_data_out,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH:0]   m_data,
   output logic [CNT_WIDTH-1:0]  m_count
);
   logic [1:0]          occ;
   logic                inflight, head, tail, fire;
   logic [2:0]          pend;
   logic [DATA_WIDTH:0] mem [2];
   assign m_valid    = (occ != 2'd0) & ~flush;
   assign fire       = m_valid & m_ready;
   assign m_data     = mem[head];
   // words owned after this edge; a new read is only safe while this stays below 2
   assign pend       = {1'b0, occ} + {2'b00, inflight} - {2'b00, fire};
   assign fifo_rd_en = ~rst & ~flush & ~fifo_empty & (pend < 3'd2);
   always_ff @(posedge clk) begin
      if (rst) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         head     <= 1'b0;
         tail     <= 1'b0;
         mem[0]   <= '0;
         mem[1]   <= '0;
         m_count  <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (fire) m_count <= m_count + CNT_WIDTH'(1);
         if (flush) begin
            occ  <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
         end else begin
            occ <= pend[1:0];
            if (inflight) begin
               mem[tail] <= fifo_data_out;
               tail      <= ~tail;
            end
            if (fire) head <= ~head;
         end
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed and random stimulus against a queue-based model of
// the FIFO, the words in flight and the words waiting downstream.
module tb_fifo_rd_stream_adapter;
   logic        clk = 1'b0, rst = 1'b1, fifo_empty = 1'b1, flush = 1'b0, m_ready = 1'b0;
   logic [7:0]  fifo_data_out = 8'h00;
   logic        fifo_rd_en, m_valid;
   logic [7:0]  m_data;
   logic [15:0] m_count;
   int          n_asrt = 0, n_fail = 0, rd_pulses = 0, cnt = 0;
   logic [7:0]  fq[$], bq[$];
   logic        pv = 1'b0;
   logic [7:0]  pw = 8'h00;
   fifo_rd_stream_adapter #(.DATA_WIDTH(7), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
      .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_count(m_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      fifo_empty = 1'b0;
   endtask
   // one clock: check outputs mid-cycle, then advance the model and the FIFO across the edge
   task automatic tick();
      logic fe, re, rd_s, popped;
      logic [7:0] w;
      w = 8'h00;
      popped = 1'b0;
      @(negedge clk);
      fe = (bq.size() != 0) && m_ready && !flush;
      re = !rst && !flush && !fifo_empty && ((bq.size() + int'(pv) - int'(fe)) < 2);
      chk("m_valid", 32'(m_valid), 32'((bq.size() != 0) && !flush));
      chk("rd_en", 32'(fifo_rd_en), 32'(re));
      chk("m_count", 32'(m_count), 32'(cnt));
      if (m_valid && bq.size() != 0) chk("m_data", 32'(m_data), 32'(bq[0]));
      rd_s = fifo_rd_en;
      rd_pulses += int'(rd_s);
      @(posedge clk);
      if (rst) begin
         bq.delete();
         cnt = 0;
      end else if (flush) begin
         bq.delete();
      end else begin
         if (fe) begin
            void'(bq.pop_front());
            cnt = (cnt + 1) % 65536;
         end
         if (pv) bq.push_back(pw);
      end
      if (rd_s && fq.size() != 0) begin
         w = fq.pop_front();
         popped = 1'b1;
      end
      pv = re;
      pw = w;
      #1;
      fifo_data_out = popped ? w : 8'($urandom);
      fifo_empty = (fq.size() == 0);
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   initial begin
      int c0;
      logic reached;
      @(posedge clk);
      #1;
      tick();
      chk("rst_valid", 32'(m_valid), 32'h0);
      chk("rst_data", 32'(m_data), 32'h0);
      chk("rst_count", 32'(m_count), 32'h0);
      rst = 1'b0;
      m_ready = 1'b1;
      rd_pulses = 0;
      push(8'h5A);
      ticks(6);
      chk("t1_rd_pulses", 32'(rd_pulses), 32'd1);
      chk("t1_count", 32'(m_count), 32'd1);
      rd_pulses = 0;
      for (int i = 0; i < 8; i++) push(8'(i));
      ticks(12);
      chk("t2_rd_pulses", 32'(rd_pulses), 32'd8);
      chk("t2_count", 32'(m_count), 32'd9);
      m_ready = 1'b0;
      rd_pulses = 0;
      for (int i = 0; i < 5; i++) push(8'(i));
      ticks(10);
      chk("t3_rd_pulses", 32'(rd_pulses), 32'd2);
      chk("t3_hold", 32'(m_data), 32'h00);
      m_ready = 1'b1;
      ticks(8);
      chk("t3_count", 32'(m_count), 32'd14);
      c0 = int'(m_count);
      for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
      for (int i = 0; i < 50; i++) begin
         m_ready = ~m_ready;
         tick();
      end
      chk("t4_count", 32'(m_count), 32'(c0 + 16));
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
      reached = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         tick();
         reached = pv && (bq.size() != 0);
      end
      chk("t5_reach", 32'(reached), 32'h1);
      c0 = int'(m_count);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_valid", 32'(m_valid), 32'h0);
      chk("t5_count_kept", 32'(m_count), 32'(c0));
      ticks(12);
      for (int i = 0; i < 10; i++) push(8'(8'hC0 + i));
      ticks(4);
      rst = 1'b1;
      tick();
      chk("t6_valid", 32'(m_valid), 32'h0);
      chk("t6_data", 32'(m_data), 32'h0);
      chk("t6_count", 32'(m_count), 32'h0);
      chk("t6_rd_en", 32'(fifo_rd_en), 32'h0);
      tick();
      rst = 1'b0;
      chk("t6_data_after", 32'(m_data), 32'h0);
      ticks(20);
      for (int i = 0; i < 400; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) push(8'($urandom));
         flush = ($urandom_range(0, 24) == 0);
         rst = ($urandom_range(0, 96) == 0);
         tick();
      end
      flush = 1'b0;
      rst = 1'b0;
      m_ready = 1'b1;
      ticks(300);
      chk("drain_valid", 32'(m_valid), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
